pa_sysmap_lookup_arb: RTL and testbench

// - Shares one pa_sysmap_access lookup port between IFU and LSU: arbitrates, pipelines PA->flag lookup, returns 5-bit attr flags.
// - Sits between ifu/lsu and pa_sysmap_top; also fences lookups against sysmap table rewrites from pa_sysmap_busif (cfg req/ack).

---
 rtl/pa_sysmap_lookup_arb.sv | 83 ++++++++
 tb/tb_pa_sysmap_lookup_arb.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pa_sysmap_lookup_arb.sv
// pa_sysmap_lookup_arb: IFU/LSU arbiter for the shared sysmap access port with a 2-stage lookup pipeline and cfg-write fence.
// Define PA_SYSMAP_ARB_LSU_PRIO_EN for fixed LSU priority with an IFU starvation guard; default is round-robin.
module pa_sysmap_lookup_arb #(
   parameter int ADDR_WIDTH = 20,
   parameter int FLG_WIDTH  = 5,
   parameter int STARVE_MAX = 4
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  ifu_arb_req,
   input  logic [31:0]           ifu_arb_pa,
   output logic                  arb_ifu_gnt,
   output logic                  arb_ifu_vld,
   output logic [FLG_WIDTH-1:0]  arb_ifu_flg,
   input  logic                  lsu_arb_req,
   input  logic [31:0]           lsu_arb_pa,
   output logic                  arb_lsu_gnt,
   output logic                  arb_lsu_vld,
   output logic [FLG_WIDTH-1:0]  arb_lsu_flg,
   output logic [ADDR_WIDTH-1:0] arb_acc_pa,
   input  logic [FLG_WIDTH-1:0]  acc_arb_flg,
   input  logic                  busif_arb_cfg_req,
   output logic                  arb_busif_cfg_ack
);
   typedef enum logic [1:0] {IDLE, DRAIN, ACK} cfg_st_e;
   cfg_st_e st_q, st_d;
   logic hold, contested, ifu_win, s1_vld_q, s1_lsu_q, s2_vld_q, s2_lsu_q;
   logic [ADDR_WIDTH-1:0] s1_pa_q;
   logic [FLG_WIDTH-1:0] ifu_flg_q, lsu_flg_q;
   logic unused_pa;
   assign unused_pa = ^{ifu_arb_pa[31-ADDR_WIDTH:0], lsu_arb_pa[31-ADDR_WIDTH:0]};
   // A rising cfg_req blocks grants in the same cycle, before the FSM leaves IDLE.
   assign hold      = busif_arb_cfg_req | (st_q != IDLE);
   assign contested = ifu_arb_req & lsu_arb_req & ~hold;
`ifdef PA_SYSMAP_ARB_LSU_PRIO_EN
   logic [3:0] starve_cnt_q;
   assign ifu_win = starve_cnt_q == 4'(STARVE_MAX);
   always_ff @(posedge forever_cpuclk or posedge cpurst)
      if (cpurst) starve_cnt_q <= '0;
      else if (arb_ifu_gnt) starve_cnt_q <= '0;
      else if (contested) starve_cnt_q <= starve_cnt_q + 4'd1;
`else
   logic rr_lsu_q;
   logic [3:0] unused_starve;
   assign unused_starve = 4'(STARVE_MAX);
   assign ifu_win = ~rr_lsu_q;
   always_ff @(posedge forever_cpuclk or posedge cpurst)
      if (cpurst) rr_lsu_q <= 1'b0;
      else if (contested) rr_lsu_q <= ifu_win;
`endif
   assign arb_ifu_gnt = ifu_arb_req & ~hold & (~lsu_arb_req | ifu_win);
   assign arb_lsu_gnt = lsu_arb_req & ~hold & (~ifu_arb_req | ~ifu_win);
   always_comb begin
      st_d = ~busif_arb_cfg_req ? IDLE : ((st_q == ACK) | ~(s1_vld_q | s2_vld_q)) ? ACK : DRAIN;
   end
   always_ff @(posedge forever_cpuclk or posedge cpurst)
      if (cpurst) begin
         st_q      <= IDLE;
         s1_vld_q  <= 1'b0;
         s1_lsu_q  <= 1'b0;
         s1_pa_q   <= '0;
         s2_vld_q  <= 1'b0;
         s2_lsu_q  <= 1'b0;
         ifu_flg_q <= '0;
         lsu_flg_q <= '0;
      end else begin
         st_q     <= st_d;
         s1_vld_q <= arb_ifu_gnt | arb_lsu_gnt;
         s1_lsu_q <= arb_lsu_gnt;
         if (arb_ifu_gnt | arb_lsu_gnt)
            s1_pa_q <= arb_lsu_gnt ? lsu_arb_pa[31 -: ADDR_WIDTH] : ifu_arb_pa[31 -: ADDR_WIDTH];
         s2_vld_q <= s1_vld_q;
         s2_lsu_q <= s1_lsu_q;
         if (s1_vld_q & ~s1_lsu_q) ifu_flg_q <= acc_arb_flg;
         if (s1_vld_q & s1_lsu_q) lsu_flg_q <= acc_arb_flg;
      end
   assign arb_ifu_vld       = s2_vld_q & ~s2_lsu_q;
   assign arb_lsu_vld       = s2_vld_q & s2_lsu_q;
   assign arb_ifu_flg       = ifu_flg_q;
   assign arb_lsu_flg       = lsu_flg_q;
   assign arb_acc_pa        = s1_vld_q ? s1_pa_q : '0;
   assign arb_busif_cfg_ack = st_q == ACK;
endmodule

// File: tb/tb_pa_sysmap_lookup_arb.sv
// tb_pa_sysmap_lookup_arb: randomized bench for pa_sysmap_lookup_arb against a queue-based lookup model.
module tb_pa_sysmap_lookup_arb;
   localparam int SM = 4;
   typedef struct {int due; bit lsu; logic [19:0] page; logic [4:0] flg;} ent_t;
   logic clk = 0, rst;
   logic ifu_req, lsu_req, ifu_gnt, lsu_gnt, ifu_vld, lsu_vld, cfg_req, cfg_ack;
   logic [31:0] ifu_pa, lsu_pa;
   logic [4:0] ifu_flg, lsu_flg, acc_flg, ver;
   logic [19:0] acc_pa;
   int n_chk = 0, n_err = 0, cyc = 0, m_starve = 0;
   bit m_drain = 0, m_ack = 0, m_ifu_first = 1, last_gi = 0, last_gl = 0;
   logic [4:0] e_ifu_flg = 0, e_lsu_flg = 0;
   ent_t q[$];

   always #5 clk = ~clk;
   // Stand-in for the sysmap table: flags are a function of page and table version.
   assign acc_flg = acc_pa[4:0] ^ 5'h12 ^ ver;

   pa_sysmap_lookup_arb #(.ADDR_WIDTH(20), .FLG_WIDTH(5), .STARVE_MAX(SM)) dut (
      .forever_cpuclk(clk), .cpurst(rst),
      .ifu_arb_req(ifu_req), .ifu_arb_pa(ifu_pa), .arb_ifu_gnt(ifu_gnt), .arb_ifu_vld(ifu_vld), .arb_ifu_flg(ifu_flg),
      .lsu_arb_req(lsu_req), .lsu_arb_pa(lsu_pa), .arb_lsu_gnt(lsu_gnt), .arb_lsu_vld(lsu_vld), .arb_lsu_flg(lsu_flg),
      .arb_acc_pa(acc_pa), .acc_arb_flg(acc_flg),
      .busif_arb_cfg_req(cfg_req), .arb_busif_cfg_ack(cfg_ack));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ifu_gnt"}, 32'(ifu_gnt), 0);
      chk({tag, "_lsu_gnt"}, 32'(lsu_gnt), 0);
      chk({tag, "_ifu_vld"}, 32'(ifu_vld), 0);
      chk({tag, "_lsu_vld"}, 32'(lsu_vld), 0);
      chk({tag, "_ifu_flg"}, 32'(ifu_flg), 0);
      chk({tag, "_lsu_flg"}, 32'(lsu_flg), 0);
      chk({tag, "_acc_pa"}, 32'(acc_pa), 0);
      chk({tag, "_ack"}, 32'(cfg_ack), 0);
   endtask

   task automatic cycle_check();
      bit hold, gi, gl, empty, ev_i, ev_l;
      logic [19:0] e_pa, pg;
      @(negedge clk);
      hold = cfg_req | m_drain | m_ack;
      gi = 0; gl = 0; ev_i = 0; ev_l = 0; e_pa = 0; empty = 1;
      if (!hold) begin
         if (ifu_req && lsu_req) begin
`ifdef PA_SYSMAP_ARB_LSU_PRIO_EN
            gi = m_starve >= SM;
`else
            gi = m_ifu_first;
`endif
            gl = !gi;
         end else begin
            gi = ifu_req;
            gl = lsu_req;
         end
      end
      foreach (q[k]) begin
         if (q[k].due == cyc + 1) begin
            e_pa = q[k].page;
            q[k].flg = q[k].page[4:0] ^ 5'h12 ^ ver;
            empty = 0;
         end
         if (q[k].due == cyc) begin
            if (q[k].lsu) begin ev_l = 1; e_lsu_flg = q[k].flg; end
            else begin ev_i = 1; e_ifu_flg = q[k].flg; end
            empty = 0;
         end
      end
      chk("ifu_gnt", 32'(ifu_gnt), 32'(gi));
      chk("lsu_gnt", 32'(lsu_gnt), 32'(gl));
      chk("ifu_vld", 32'(ifu_vld), 32'(ev_i));
      chk("lsu_vld", 32'(lsu_vld), 32'(ev_l));
      chk("ifu_flg", 32'(ifu_flg), 32'(e_ifu_flg));
      chk("lsu_flg", 32'(lsu_flg), 32'(e_lsu_flg));
      chk("acc_pa", 32'(acc_pa), 32'(e_pa));
      chk("cfg_ack", 32'(cfg_ack), 32'(m_ack));
      if (gi || gl) begin
         pg = gl ? lsu_pa[31:12] : ifu_pa[31:12];
         q.push_back('{cyc + 2, gl, pg, 5'd0});
      end
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      if (!hold && ifu_req && lsu_req) m_ifu_first = !gi;
      if (gi) m_starve = 0;
      else if (gl && ifu_req) m_starve++;
      if (m_ack) m_ack = cfg_req;
      else if (m_drain) begin
         m_ack = cfg_req && empty;
         m_drain = cfg_req && !empty;
      end else if (cfg_req) begin
         m_ack = empty;
         m_drain = !empty;
      end
      last_gi = gi;
      last_gl = gl;
      cyc++;
   endtask

   task automatic run(input int n, input int pi, input int pl, input int pc);
      repeat (n) begin
         cycle_check();
         @(posedge clk); #1;
         if (!ifu_req || last_gi) begin ifu_req = $urandom_range(99) < pi; ifu_pa = $urandom; end
         if (!lsu_req || last_gl) begin lsu_req = $urandom_range(99) < pl; lsu_pa = $urandom; end
         if (pc >= 0) cfg_req = cfg_req ? ($urandom_range(2) != 0) : ($urandom_range(99) < pc);
         if (cfg_ack && $urandom_range(3) == 0) ver = ver + 5'd1;
      end
   endtask

   task automatic reset_pulse();
      #2 rst = 1;
      ifu_req = 0; lsu_req = 0; cfg_req = 0;
      #1 chk_zero("midrst");
      q.delete();
      m_drain = 0; m_ack = 0; m_ifu_first = 1; m_starve = 0;
      e_ifu_flg = 0; e_lsu_flg = 0; last_gi = 0; last_gl = 0;
      @(negedge clk); #1 rst = 0;
   endtask

   initial begin
      rst = 1; ifu_req = 0; lsu_req = 0; ifu_pa = 0; lsu_pa = 0; cfg_req = 0; ver = 0;
      repeat (2) @(posedge clk);
      #1 chk_zero("rst");
      @(negedge clk); rst = 0;
      @(posedge clk); #1;
      ifu_req = 1; ifu_pa = 32'h8000_1234;
      run(4, 0, 0, -1);
      chk("single_flg", 32'(ifu_flg), 32'h13);
      ifu_req = 1; lsu_req = 1;
      run(8, 100, 100, -1);
      cfg_req = 1;
      run(5, 100, 100, -1);
      cfg_req = 0;
      run(3, 100, 100, -1);
      ifu_req = 0; lsu_req = 0;
      run(3, 0, 0, -1);
      ifu_req = 1; cfg_req = 1;
      run(3, 0, 0, -1);
      cfg_req = 0;
      run(4, 0, 0, -1);
      ifu_req = 1; lsu_req = 1;
      run(3, 100, 100, -1);
      reset_pulse();
      run(6, 100, 100, -1);
      repeat (4) begin
         run(500, 60, 60, 4);
         reset_pulse();
      end
      run(300, 100, 100, 2);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
